// File: rtl/dw_window_gen.sv
// ---------------------------------------------------------------------------
// dw_window_gen
// Streaming 3x3 sliding-window generator for a depthwise convolution layer.
// Pixels arrive in raster order, one per in_valid, all CH channels packed.
// Two line buffers (rows r-2 and r-1) plus a 3x3 window register per channel
// build the window. A window is emitted one cycle after the pixel that
// completes it, subject to the stride. Convolution is unpadded.
//
// Ports
//   clk        in   rising-edge clock
//   rstn       in   asynchronous active-low reset
//   in_valid   in   pixel present on in_pix (always accepted)
//   in_sof     in   with in_valid: pixel is (row 0, col 0) of a new frame
//   in_pix     in   CH*DW pixel, channel ch at [ch*DW +: DW]
//   win_valid  out  one-cycle pulse: win_act holds a new window
//   win_act    out  9*CH*DW window, channel ch tap t at [(ch*9+t)*DW +: DW],
//                   t = ky*3+kx, ky=0 top row, kx=0 left column
//   win_last   out  with win_valid: final window of the frame
// ---------------------------------------------------------------------------
module dw_window_gen #(
  parameter int CH     = 8,
  parameter int DW     = 16,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int STRIDE = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [CH*DW-1:0]     in_pix,
  output logic                 win_valid,
  output logic [9*CH*DW-1:0]   win_act,
  output logic                 win_last
);

  localparam int PW = CH * DW;
  localparam int WW = 9 * PW;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
  // Position of the final qualifying window centre-plus-one in each axis.
  localparam logic [CW-1:0] COL_LAST = CW'(2 + ((IMG_W - 3) / STRIDE) * STRIDE);
  localparam logic [RW-1:0] ROW_LAST = RW'(2 + ((IMG_H - 3) / STRIDE) * STRIDE);

  logic [CW-1:0] col_reg, col_next, cur_col;
  logic [RW-1:0] row_reg, row_next, cur_row;

  logic          win_valid_reg;
  logic          win_last_reg;
  logic [WW-1:0] win_act_reg;

  logic [WW-1:0] win_reg;
  logic [WW-1:0] win_next;

  logic [PW-1:0] lb_top [IMG_W];
  logic [PW-1:0] lb_mid [IMG_W];
  logic [PW-1:0] new_col [3];

  logic row_ok, col_ok, emit, at_last;

  // A start-of-frame pixel is placed at (0,0) whatever the counters say.
  assign cur_col = in_sof ? '0 : col_reg;
  assign cur_row = in_sof ? '0 : row_reg;

  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (in_valid) begin
      if (cur_col == COL_MAX) begin
        col_next = '0;
        row_next = (cur_row == ROW_MAX) ? '0 : cur_row + RW'(1);
      end else begin
        col_next = cur_col + CW'(1);
        row_next = cur_row;
      end
    end
  end

  // Stride is 1 or 2; for stride 2, (x-2)%2==0 reduces to x being even.
  assign row_ok  = (cur_row >= RW'(2)) && ((STRIDE == 1) || !cur_row[0]);
  assign col_ok  = (cur_col >= CW'(2)) && ((STRIDE == 1) || !cur_col[0]);
  assign emit    = in_valid && row_ok && col_ok;
  assign at_last = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  // New window column, top to bottom: row-2, row-1, current pixel.
  assign new_col[0] = lb_top[cur_col];
  assign new_col[1] = lb_mid[cur_col];
  assign new_col[2] = in_pix;

  // Window shifts left one column per accepted pixel; new column at kx=2.
  genvar gi, gk;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      for (gk = 0; gk < 3; gk++) begin : g_ky
        assign win_next[(gi*9 + gk*3 + 0)*DW +: DW] = win_reg[(gi*9 + gk*3 + 1)*DW +: DW];
        assign win_next[(gi*9 + gk*3 + 1)*DW +: DW] = win_reg[(gi*9 + gk*3 + 2)*DW +: DW];
        assign win_next[(gi*9 + gk*3 + 2)*DW +: DW] = new_col[gk][gi*DW +: DW];
      end
    end
  endgenerate

  // Datapath storage: not reset, only ever read after being rewritten
  // within the current frame.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb_top[cur_col] <= new_col[1];
      lb_mid[cur_col] <= in_pix;
      win_reg         <= win_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_reg       <= '0;
      row_reg       <= '0;
      win_valid_reg <= 1'b0;
      win_last_reg  <= 1'b0;
      win_act_reg   <= '0;
    end else begin
      col_reg       <= col_next;
      row_reg       <= row_next;
      win_valid_reg <= emit;
      win_last_reg  <= emit && at_last;
      if (emit) begin
        win_act_reg <= win_next;
      end
    end
  end

  assign win_valid = win_valid_reg;
  assign win_last  = win_last_reg;
  assign win_act   = win_act_reg;

endmodule
